ex_muldiv: RTL

RV32M multiply/divide unit in the EX stage. It consumes the instruction and operands registered by the ID/EX pipeline register and runs MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU as a multi-cycle operation. While busy it raises a hold request to ctrl, which freezes ID/EX and everything upstream. It returns a registered write-back result for the regfile path.

---
 rtl/ex_muldiv_pkg.sv | 27 ++
 rtl/ex_div_iter.sv | 46 ++++
 rtl/gnrl_dfflr.sv | 17 +
 rtl/ex_muldiv.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared constants, FSM encoding and helpers for the RV32M multiply/divide unit.
// Consumed by ex_muldiv and its testbench-facing decode.
package ex_muldiv_pkg;

   localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
   localparam logic [6:0] FUNCT7_M      = 7'b0000001;

   localparam logic [2:0] INST_MUL    = 3'b000;
   localparam logic [2:0] INST_MULH   = 3'b001;
   localparam logic [2:0] INST_MULHSU = 3'b010;
   localparam logic [2:0] INST_MULHU  = 3'b011;
   localparam logic [2:0] INST_DIV    = 3'b100;
   localparam logic [2:0] INST_DIVU   = 3'b101;
   localparam logic [2:0] INST_REM    = 3'b110;
   localparam logic [2:0] INST_REMU   = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } md_state_e;

   function automatic logic [31:0] neg32(input logic n, input logic [31:0] v);
      return n ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/ex_div_iter.sv
// Radix-2 restoring divider datapath; one quotient bit per busy cycle.
module ex_div_iter (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic        busy_i,
   input  logic [31:0] dividend_i,
   input  logic [31:0] divisor_i,
   output logic [31:0] quotient_o,
   output logic [31:0] remainder_o
);

   logic [63:0] rq_q, rq_d;
   logic [31:0] dvs_q, dvs_d;
   logic [32:0] top;
   logic [32:0] sub;

   always_comb begin
      rq_d  = rq_q;
      dvs_d = dvs_q;
      top   = rq_q[63:31];
      sub   = top - {1'b0, dvs_q};
      if (start_i) begin
         rq_d  = {32'd0, dividend_i};
         dvs_d = divisor_i;
      end else if (busy_i) begin
         // Partial remainder is always below the divisor, so a borrow is sub[32].
         if (!sub[32]) rq_d = {sub[31:0], rq_q[30:0], 1'b1};
         else          rq_d = {rq_q[62:0], 1'b0};
      end
   end

   assign quotient_o  = rq_d[31:0];
   assign remainder_o = rq_d[63:32];

   always_ff @(posedge clk) begin
      if (rst) begin
         rq_q  <= '0;
         dvs_q <= '0;
      end else begin
         rq_q  <= rq_d;
         dvs_q <= dvs_d;
      end
   end

endmodule

// File: rtl/gnrl_dfflr.sv
// Generic load-enable flop with synchronous active-high reset to zero.
module gnrl_dfflr #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          lden,
   input  logic [DW-1:0] dnxt,
   output logic [DW-1:0] qout
);

   always_ff @(posedge clk) begin
      if (rst) qout <= '0;
      else if (lden) qout <= dnxt;
   end

endmodule

// File: rtl/ex_muldiv.sv
// RV32M multiply/divide unit for the EX stage (IDLE/CALC/DONE FSM).
// Define MULDIV_FAST_MUL_EN for single-cycle multiplies.
module ex_muldiv
   import ex_muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     inst_i,
   input  logic [XLEN-1:0] op1_i,
   input  logic [XLEN-1:0] op2_i,
   input  logic            regs_wen_i,
   input  logic [4:0]      rd_addr_i,
   input  logic            flush_i,
   output logic            hold_req_o,
   output logic [XLEN-1:0] result_o,
   output logic            regs_wen_o,
   output logic [4:0]      rd_addr_o
);

   md_state_e   state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [63:0] acc_q, acc_d;
   logic [31:0] a_q, a_d;
   logic [2:0]  f3_q, f3_d;
   logic [4:0]  rd_q, rd_d;
   logic        wen_q, wen_d;
   logic        negq_q, negq_d;
   logic        negr_q, negr_d;
   logic [32:0] mul_sum;

   logic [2:0]  funct3;
   logic        is_m, s1, s2, is_div, div0, ovf, special, start;
   logic [31:0] abs1, abs2;
   logic        fast_mul;
   logic [31:0] fast_res;
   logic [31:0] div_q, div_r;
   logic        unused_inst;

   assign funct3  = inst_i[14:12];
   assign is_m    = (inst_i[6:0] == INST_TYPE_R_M) && (inst_i[31:25] == FUNCT7_M);
   assign is_div  = funct3[2];
   assign s1      = is_div ? ~funct3[0] : (funct3 != INST_MULHU);
   assign s2      = is_div ? ~funct3[0] : (funct3[1] == 1'b0);
   assign abs1    = neg32(s1 & op1_i[31], op1_i);
   assign abs2    = neg32(s2 & op2_i[31], op2_i);
   assign div0    = (op2_i == 32'd0);
   assign ovf     = s1 && (op1_i == 32'h8000_0000) && (op2_i == 32'hFFFF_FFFF);
   assign special = is_div && (div0 || ovf);
   assign start   = (state_q == S_IDLE) && is_m && !flush_i;

   assign unused_inst = ^{inst_i[24:15], inst_i[11:7]};

`ifdef MULDIV_FAST_MUL_EN
   logic signed [32:0] fa, fb;
   logic signed [65:0] fp;
   logic               unused_fp;
   assign fa        = $signed({s1 & op1_i[31], op1_i});
   assign fb        = $signed({s2 & op2_i[31], op2_i});
   assign fp        = fa * fb;
   assign fast_mul  = ~funct3[2];
   assign fast_res  = (funct3 == INST_MUL) ? fp[31:0] : fp[63:32];
   assign unused_fp = ^fp[65:64];
`else
   assign fast_mul = 1'b0;
   assign fast_res = '0;
`endif

   ex_div_iter u_div (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start && is_div && !special),
      .busy_i     ((state_q == S_CALC) && f3_q[2]),
      .dividend_i (abs1),
      .divisor_i  (abs2),
      .quotient_o (div_q),
      .remainder_o(div_r)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      a_d     = a_q;
      f3_d    = f3_q;
      rd_d    = rd_q;
      wen_d   = wen_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               f3_d    = funct3;
               rd_d    = rd_addr_i;
               wen_d   = regs_wen_i;
               negq_d  = (s1 & op1_i[31]) ^ (s2 & op2_i[31]);
               negr_d  = s1 & op1_i[31];
               a_d     = abs1;
               acc_d   = {32'd0, abs2};
               cnt_d   = '0;
               state_d = (special || fast_mul) ? S_DONE : S_CALC;
            end
         end
         S_CALC: begin
            if (flush_i) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               if (!f3_q[2]) acc_d = {mul_sum, acc_q[31:1]};
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd31) state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         a_q     <= '0;
         f3_q    <= '0;
         rd_q    <= '0;
         wen_q   <= 1'b0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         a_q     <= a_d;
         f3_q    <= f3_d;
         rd_q    <= rd_d;
         wen_q   <= wen_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
      end
   end

   logic [63:0] prod;
   logic [31:0] quot, rem, calc_res, spec_res, res_d;
   logic        done_go, wen_out_d;
   logic [4:0]  rd_out_d;

   always_comb begin
      prod     = negq_q ? (~acc_d + 64'd1) : acc_d;
      quot     = neg32(negq_q, div_q);
      rem      = neg32(negr_q, div_r);
      calc_res = '0;
      unique case (1'b1)
         (f3_q == INST_MUL):          calc_res = prod[31:0];
         (f3_q[2:2] == 1'b0
          && f3_q != INST_MUL):       calc_res = prod[63:32];
         (f3_q[2:1] == 2'b10):        calc_res = quot;
         (f3_q[2:1] == 2'b11):        calc_res = rem;
         default:                     calc_res = '0;
      endcase
      // Divide-by-zero and signed overflow are answered without iterating.
      if (div0) spec_res = funct3[1] ? op1_i : 32'hFFFF_FFFF;
      else      spec_res = funct3[1] ? 32'd0 : 32'h8000_0000;
   end

   assign done_go   = (state_d == S_DONE);
   assign res_d     = (state_q == S_IDLE) ? (special ? spec_res : fast_res) : calc_res;
   assign wen_out_d = done_go && ((state_q == S_IDLE) ? regs_wen_i : wen_q);
   assign rd_out_d  = (state_q == S_IDLE) ? rd_addr_i : rd_q;

   gnrl_dfflr #(.DW(XLEN)) u_res (
      .clk(clk), .rst(rst), .lden(done_go), .dnxt(res_d), .qout(result_o)
   );

   gnrl_dfflr #(.DW(5)) u_rd (
      .clk(clk), .rst(rst), .lden(done_go), .dnxt(rd_out_d), .qout(rd_addr_o)
   );

   gnrl_dfflr #(.DW(1)) u_wen (
      .clk(clk), .rst(rst), .lden(1'b1), .dnxt(wen_out_d), .qout(regs_wen_o)
   );

   always_comb begin
      hold_req_o = 1'b0;
      unique case (state_q)
         S_IDLE:  hold_req_o = is_m && !flush_i;
         S_CALC:  hold_req_o = !flush_i;
         default: hold_req_o = 1'b0;
      endcase
   end

endmodule
